iob_requester: RTL and testbench
================================

IOB_REQUESTER -- requirements
Module: iob_requester

Interface
REQ-001 SHALL have parameter POSTWR, default 1; 1 = writes are posted (CPU acked at capture), 0 = writes acked at I/O completion.
REQ-002 SHALL have parameter TMAX, default 1023; cycles allowed in REQ+ACT before timeout abort (10-bit counter).
REQ-003 SHALL have one clock and an asynchronous active-high reset: C16M in 1, 16 MHz clock, all state on rising edge.
REQ-004 SHALL have RES in 1, asynchronous active-high reset.
REQ-005 SHALL have CPUREQ in 1, CPU I/O-space cycle valid; level, held until after CPUACK.
REQ-006 SHALL have CPURnW in 1, 1 = read.
REQ-007 SHALL have CPULDS, CPUUDS in 1 each, byte strobes, active-high.
REQ-008 SHALL have CPUACK out 1, one-cycle pulse terminating the CPU cycle.
REQ-009 SHALL have IOREQ out 1, I/O bus request to bus master.
REQ-010 SHALL have IORW out 1 (1 = read), IOLDS out 1, IOUDS out 1, latched cycle attributes.
REQ-011 SHALL have IOACT in 1, master cycle active; IODONE in 1, master termination.
REQ-012 SHALL have ALE1 out 1, one-cycle pulse latching CPU address/data into outgoing latch.
REQ-013 SHALL have PWPEND out 1, posted write outstanding; TOERR out 1, sticky timeout flag.

Function
REQ-014 SHALL implement states IDLE, REQ, ACT, DONE; all outputs registered.
REQ-015 IDLE: on CPUREQ=1 and served=0, SHALL go to REQ, set IOREQ=1, load IORW/IOLDS/IOUDS from CPURnW/CPULDS/CPUUDS, pulse ALE1, clear timeout counter.
REQ-016 Capture of a write with POSTWR=1 SHALL pulse CPUACK in the same edge as ALE1 and set PWPEND=1.
REQ-017 served flag SHALL set on every CPUACK and clear on any cycle with CPUREQ=0; a held CPUREQ SHALL never be captured twice.
REQ-018 REQ: IOREQ SHALL stay 1 until IOACT sampled 1, then IOREQ=0 and go to ACT.
REQ-019 ACT: on IODONE sampled 1, SHALL go to DONE; pulse CPUACK if the CPU cycle was not yet acked (read, or write with POSTWR=0).
REQ-020 REQ with IOACT=1 and IODONE=1 sampled together SHALL go directly to DONE with IOREQ=0 and same ack rule.
REQ-021 DONE: SHALL wait for IOACT=0, then go to IDLE, clear PWPEND; IORW/IOLDS/IOUDS SHALL hold their values until the next capture.
REQ-022 CPUREQ arriving while not IDLE (e.g. PWPEND=1) SHALL receive no CPUACK and no ALE1 until return to IDLE; capture then occurs on the first IDLE cycle.
REQ-023 Timeout counter SHALL increment each cycle in REQ or ACT, saturate at TMAX; reaching TMAX SHALL force IOREQ=0, pulse CPUACK if unacked, set TOERR=1, go to IDLE, clear PWPEND.
REQ-024 CPUACK SHALL never be high two consecutive cycles; at most one CPUACK per captured cycle.
REQ-025 ALE1 SHALL pulse exactly once per capture and never outside IDLE->REQ.

Reset
REQ-026 RES=1 SHALL asynchronously force state IDLE, served=0, counter=0, and IOREQ, IORW, IOLDS, IOUDS, CPUACK, ALE1, PWPEND, TOERR all 0.
REQ-027 RES asserted mid-cycle SHALL drop IOREQ immediately with no CPUACK; after release, block SHALL resume capture only on a fresh CPUREQ evaluation in IDLE.
REQ-028 TOERR SHALL clear only on RES.

Verification
REQ-029 Posted word write: CPUREQ=1, CPURnW=0, LDS=UDS=1 at edge 0 -> edge 1: IOREQ=1, IORW=0, ALE1=1, CPUACK=1, PWPEND=1; IOACT at edge 3 -> IOREQ=0; IODONE then IOACT low -> PWPEND=0, no second CPUACK.
REQ-030 Byte read: CPURnW=1, LDS=1, UDS=0 -> IOLDS=1, IOUDS=0, no CPUACK until IODONE sampled; CPUACK one cycle after IODONE edge, exactly one cycle wide.
REQ-031 Back-to-back: posted write then read request held during PWPEND=1 -> read captured first cycle after IOACT falls; ALE1 count = 2, CPUACK count = 2.
REQ-032 Timeout: TMAX=16, read issued, IOACT never asserted -> at 16th REQ cycle IOREQ=0, CPUACK pulse, TOERR=1 until RES.
REQ-033 Reset mid-ACT: RES pulsed during read with IOACT=1 -> all outputs 0 immediately, no CPUACK; CPUREQ still high after release -> recaptured, IOREQ=1 next edge.

Source files
------------

// File: rtl/iob_requester_if.sv
// iob_requester_if: CPU-side request and I/O-bus-master handshake signals of the requester
interface iob_requester_if;
  logic cpureq;
  logic cpurnw;
  logic cpulds;
  logic cpuuds;
  logic cpuack;
  logic ioreq;
  logic iorw;
  logic iolds;
  logic iouds;
  logic ioact;
  logic iodone;
  logic ale1;
  logic pwpend;
  logic toerr;
  modport master (
    input  cpureq, cpurnw, cpulds, cpuuds, ioact, iodone,
    output cpuack, ioreq, iorw, iolds, iouds, ale1, pwpend, toerr
  );
  modport slave (
    output cpureq, cpurnw, cpulds, cpuuds, ioact, iodone,
    input  cpuack, ioreq, iorw, iolds, iouds, ale1, pwpend, toerr
  );
endinterface

// File: rtl/iob_requester.sv
// iob_requester: turns CPU I/O-space cycles into I/O bus master requests, with posted writes and timeout abort
module iob_requester #(
  parameter bit POSTWR = 1'b1,
  parameter int TMAX   = 1023
) (
  input logic c16m,
  input logic res,
  iob_requester_if.master bus
);
  typedef enum logic [1:0] {IDLE, REQ, ACT, DONE} state_t;
  localparam logic [9:0] TM = 10'(TMAX);
  state_t state, state_d;
  logic served, served_d, acked, acked_d;
  logic [9:0] cnt, cnt_d, cnt_inc;
  logic cap, wr_post, busy, fin, tmo;
  logic ioreq_d, iorw_d, iolds_d, iouds_d, cpuack_d, ale1_d, pwpend_d, toerr_d;
  assign busy    = state == REQ || state == ACT;
  assign cap     = state == IDLE && bus.cpureq && !served;
  assign wr_post = cap && !bus.cpurnw && POSTWR;
  assign cnt_inc = (cnt == TM) ? cnt : cnt + 10'd1;
  assign fin     = (state == REQ && bus.ioact && bus.iodone) || (state == ACT && bus.iodone);
  // completion wins over a timeout landing on the same edge
  assign tmo     = busy && !fin && cnt_inc == TM;
  always_ff @(posedge c16m or posedge res)
    if (res) begin
      state      <= IDLE;
      served     <= 1'b0;
      acked      <= 1'b0;
      cnt        <= '0;
      bus.ioreq  <= 1'b0;
      bus.iorw   <= 1'b0;
      bus.iolds  <= 1'b0;
      bus.iouds  <= 1'b0;
      bus.cpuack <= 1'b0;
      bus.ale1   <= 1'b0;
      bus.pwpend <= 1'b0;
      bus.toerr  <= 1'b0;
    end else begin
      state      <= state_d;
      served     <= served_d;
      acked      <= acked_d;
      cnt        <= cnt_d;
      bus.ioreq  <= ioreq_d;
      bus.iorw   <= iorw_d;
      bus.iolds  <= iolds_d;
      bus.iouds  <= iouds_d;
      bus.cpuack <= cpuack_d;
      bus.ale1   <= ale1_d;
      bus.pwpend <= pwpend_d;
      bus.toerr  <= toerr_d;
    end
  always_comb begin
    state_d = state;
    case (state)
      IDLE: state_d = cap ? REQ : IDLE;
      REQ:  state_d = fin ? DONE : tmo ? IDLE : bus.ioact ? ACT : REQ;
      ACT:  state_d = fin ? DONE : tmo ? IDLE : ACT;
      DONE: state_d = bus.ioact ? DONE : IDLE;
    endcase
  end
  always_comb begin
    ioreq_d  = cap || (state == REQ && state_d == REQ);
    ale1_d   = cap;
    iorw_d   = cap ? bus.cpurnw : bus.iorw;
    iolds_d  = cap ? bus.cpulds : bus.iolds;
    iouds_d  = cap ? bus.cpuuds : bus.iouds;
    cpuack_d = wr_post || ((fin || tmo) && !acked);
    acked_d  = cap ? wr_post : acked || cpuack_d;
    // a held request stays served until the CPU lets go of it
    served_d = cpuack_d || (served && bus.cpureq);
    pwpend_d = cap ? wr_post : bus.pwpend && state_d != IDLE;
    toerr_d  = bus.toerr || tmo;
    cnt_d    = cap ? '0 : busy ? cnt_inc : cnt;
  end
endmodule

// File: tb/tb_iob_requester.sv
// tb_iob_requester: directed corner cases plus randomized CPU/I-O traffic checked by a scoreboard
module tb_iob_requester;
  logic c16m = 1'b0;
  logic res = 1'b1;
  iob_requester_if bus();
  iob_requester #(.POSTWR(1'b1), .TMAX(16)) dut (.c16m(c16m), .res(res), .bus(bus));
  always #31 c16m = ~c16m;
  int total, bad, cyc, done_cyc, ale_cnt, ack_cnt, n, io_la, io_ld;
  bit mon_en, io_en, prev_ack, t_rnw, t_lds, t_uds;
  logic [2:0] cap_q[$];
  bit ack_q[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(posedge c16m) cyc <= cyc + 1;
  // scoreboard monitor: every capture and every CPU ack consumes one expectation
  always @(negedge c16m)
    if (mon_en && !res) begin
      if (bus.ale1) begin
        ale_cnt++;
        chk("ale1_ioreq", bus.ioreq, 1);
        if (cap_q.size() == 0) chk("ale1_unexpected", cap_q.size(), 1);
        else chk("capture_attrs", {bus.iorw, bus.iolds, bus.iouds}, cap_q.pop_front());
      end
      if (bus.cpuack) begin
        ack_cnt++;
        chk("ack_consec", prev_ack, 0);
        if (ack_q.size() == 0) chk("ack_unexpected", ack_q.size(), 1);
        else if (ack_q.pop_front()) chk("posted_ack", {bus.ale1, bus.pwpend}, 2'b11);
        else chk("read_ack_cycle", cyc, done_cyc + 1);
      end
      prev_ack = bus.cpuack;
    end
  // I/O bus master: random grant and completion latencies
  initial begin
    bus.ioact = 1'b0;
    bus.iodone = 1'b0;
    forever begin
      @(negedge c16m);
      if (io_en && bus.ioreq) begin
        io_la = $urandom_range(0, 4);
        io_ld = $urandom_range(0, 4);
        repeat (io_la) @(negedge c16m);
        bus.ioact = 1'b1;
        repeat (io_ld) @(negedge c16m);
        bus.iodone = 1'b1;
        done_cyc = cyc;
        @(negedge c16m);
        bus.iodone = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge c16m);
        bus.ioact = 1'b0;
      end
    end
  end
  initial begin
    bus.cpureq = 1'b0;
    bus.cpurnw = 1'b0;
    bus.cpulds = 1'b0;
    bus.cpuuds = 1'b0;
    repeat (2) @(negedge c16m);
    chk("reset_state", {bus.ioreq, bus.iorw, bus.iolds, bus.iouds, bus.cpuack, bus.ale1, bus.pwpend, bus.toerr}, 0);
    res = 1'b0;
    @(negedge c16m);
    // posted word write
    {bus.cpureq, bus.cpurnw, bus.cpulds, bus.cpuuds} = 4'b1011;
    @(negedge c16m);
    chk("posted_capture", {bus.ioreq, bus.iorw, bus.ale1, bus.cpuack, bus.pwpend, bus.iolds, bus.iouds}, 7'b1011111);
    bus.cpureq = 1'b0;
    @(negedge c16m);
    chk("posted_req_hold", {bus.ioreq, bus.ale1, bus.cpuack}, 3'b100);
    bus.ioact = 1'b1;
    @(negedge c16m);
    chk("ioreq_drop", bus.ioreq, 0);
    bus.iodone = 1'b1;
    @(negedge c16m);
    chk("no_second_ack", {bus.cpuack, bus.pwpend}, 2'b01);
    {bus.iodone, bus.ioact} = 2'b00;
    @(negedge c16m);
    chk("pwpend_clear", {bus.pwpend, bus.cpuack}, 0);
    // byte read
    {bus.cpureq, bus.cpurnw, bus.cpulds, bus.cpuuds} = 4'b1110;
    @(negedge c16m);
    chk("byte_read_capture", {bus.iorw, bus.iolds, bus.iouds, bus.cpuack, bus.ale1}, 5'b11001);
    bus.ioact = 1'b1;
    @(negedge c16m);
    chk("read_no_early_ack", bus.cpuack, 0);
    bus.iodone = 1'b1;
    @(negedge c16m);
    chk("read_ack", bus.cpuack, 1);
    {bus.cpureq, bus.iodone, bus.ioact} = 3'b000;
    @(negedge c16m);
    chk("read_ack_width", bus.cpuack, 0);
    repeat (2) @(negedge c16m);
    // timeout with no grant
    {bus.cpureq, bus.cpurnw, bus.cpulds, bus.cpuuds} = 4'b1111;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge c16m);
      if (!bus.ioreq) break;
      n++;
    end
    chk("timeout_cycles", n, 16);
    chk("timeout_ack", {bus.cpuack, bus.toerr}, 2'b11);
    bus.cpureq = 1'b0;
    repeat (3) @(negedge c16m);
    chk("toerr_sticky", {bus.toerr, bus.cpuack, bus.ioreq}, 3'b100);
    // asynchronous reset in the middle of an active read
    {bus.cpureq, bus.cpurnw} = 2'b11;
    @(negedge c16m);
    chk("rst_test_req", bus.ioreq, 1);
    bus.ioact = 1'b1;
    @(negedge c16m);
    #5 res = 1'b1;
    #1 chk("reset_async", {bus.ioreq, bus.iorw, bus.iolds, bus.iouds, bus.cpuack, bus.ale1, bus.pwpend, bus.toerr}, 0);
    #5 res = 1'b0;
    bus.ioact = 1'b0;
    @(negedge c16m);
    chk("recapture", {bus.ioreq, bus.ale1, bus.cpuack}, 3'b110);
    {bus.ioact, bus.iodone} = 2'b11;
    @(negedge c16m);
    chk("recapture_ack", bus.cpuack, 1);
    {bus.cpureq, bus.ioact, bus.iodone} = 3'b000;
    repeat (3) @(negedge c16m);
    // randomized traffic, back-to-back requests allowed while a posted write drains
    prev_ack = 1'b0;
    mon_en = 1'b1;
    io_en = 1'b1;
    for (int t = 0; t < 40; t++) begin
      t_rnw = 1'($urandom_range(0, 1));
      t_lds = 1'($urandom_range(0, 1));
      t_uds = 1'($urandom_range(0, 1));
      cap_q.push_back({t_rnw, t_lds, t_uds});
      ack_q.push_back(!t_rnw);
      {bus.cpureq, bus.cpurnw, bus.cpulds, bus.cpuuds} = {1'b1, t_rnw, t_lds, t_uds};
      n = 0;
      do begin
        @(negedge c16m);
        n++;
      end while (!bus.cpuack && n < 60);
      if (!bus.cpuack) chk("ack_timeout", n, 0);
      bus.cpureq = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge c16m);
    end
    n = 0;
    while ((bus.ioreq || bus.pwpend || bus.ioact) && n < 100) begin
      @(negedge c16m);
      n++;
    end
    repeat (3) @(negedge c16m);
    chk("drain_idle", {bus.ioreq, bus.pwpend, bus.ioact}, 0);
    chk("ale_count", ale_cnt, 40);
    chk("ack_count", ack_cnt, 40);
    chk("queues_empty", cap_q.size() + ack_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
